// File: rtl/epoch_window_sched_if.sv
// Control and strobe bundle between the sample front end and the window sequencer.
// With SCHED_STATUS_EN defined the bundle also carries the epoch and drop counters.
interface epoch_window_sched_if;
  logic        start;
  logic        stop;
  logic        hold;
  logic        sample_valid;
  logic        ld_s1;
  logic        ld_s2;
  logic        ld_s3;
  logic        ld_s4;
  logic [3:0]  full;
  logic        out_valid;
  logic [1:0]  state;
  logic        drop;
`ifdef SCHED_STATUS_EN
  logic [15:0] epoch_cnt;
  logic [15:0] drop_cnt;

  modport master (
    output start, stop, hold, sample_valid,
    input  ld_s1, ld_s2, ld_s3, ld_s4, full, out_valid, state, drop, epoch_cnt, drop_cnt
  );
  modport slave (
    input  start, stop, hold, sample_valid,
    output ld_s1, ld_s2, ld_s3, ld_s4, full, out_valid, state, drop, epoch_cnt, drop_cnt
  );
`else
  modport master (
    output start, stop, hold, sample_valid,
    input  ld_s1, ld_s2, ld_s3, ld_s4, full, out_valid, state, drop
  );
  modport slave (
    input  start, stop, hold, sample_valid,
    output ld_s1, ld_s2, ld_s3, ld_s4, full, out_valid, state, drop
  );
`endif
endinterface

// File: rtl/epoch_window_sched.sv
// Sequencer for the cascaded 1s/5s/30s/240s window stages; SCHED_STATUS_EN adds epoch/drop counters.
// Strobes, drop and out_valid appear one cycle after the accepted sample.
// No backpressure: samples outside FILL/RUN, or in a stop cycle, are rejected and flagged on drop.
module epoch_window_sched #(
  parameter int SPS    = 250,
  parameter int N_5S   = 5,
  parameter int N_30S  = 6,
  parameter int N_240S = 8,
  parameter int D1     = 5,
  parameter int D2     = 5,
  parameter int D3     = 6,
  parameter int D4     = 8,
  parameter int CW     = 8
) (
  input logic                 clk,
  input logic                 rst,
  epoch_window_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10,
    HOLD = 2'b11
  } state_t;

  localparam logic [CW-1:0] C0_MAX = CW'(SPS - 1);
  localparam logic [7:0]    C1_MAX = 8'(N_5S - 1);
  localparam logic [7:0]    C2_MAX = 8'(N_30S - 1);
  localparam logic [7:0]    C3_MAX = 8'(N_240S - 1);
  localparam logic [7:0]    DEPTH [4] = '{8'(D1), 8'(D2), 8'(D3), 8'(D4)};

  state_t        state_q, state_d;
  logic          ret_run_q, ret_run_d;
  logic [CW-1:0] c0_q;
  logic [7:0]    c1_q, c2_q, c3_q;
  logic [7:0]    f_q [4];
  logic [7:0]    f_d [4];
  logic [3:0]    ld_q;
  logic          ov_q, drop_q;
  logic [3:0]    full_now, full_d;
  logic          accept, tick1, tick5, tick30, tick240, ov_d, drop_d;

  assign accept  = bus.sample_valid && (state_q == FILL || state_q == RUN) && !bus.stop;
  assign tick1   = accept && (c0_q == C0_MAX);
  assign tick5   = tick1  && (c1_q == C1_MAX);
  assign tick30  = tick5  && (c2_q == C2_MAX);
  assign tick240 = tick30 && (c3_q == C3_MAX);
  assign ov_d    = tick240 && (&full_d);
  assign drop_d  = bus.sample_valid && !accept;

  // Fill counts track the strobes actually presented to the stages, so a
  // stage is full only once its last load has been clocked in.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      f_d[k] = f_q[k];
      if (ld_q[k] && (f_q[k] != DEPTH[k])) f_d[k] = f_q[k] + 8'd1;
      full_d[k]   = (f_d[k] == DEPTH[k]);
      full_now[k] = (f_q[k] == DEPTH[k]);
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_run_d = ret_run_q;
    if (bus.stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.start && !bus.hold) state_d = FILL;
        FILL: begin
          if (bus.hold) begin
            state_d   = HOLD;
            ret_run_d = 1'b0;
          end else if (&full_d) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.hold) begin
            state_d   = HOLD;
            ret_run_d = 1'b1;
          end
        end
        HOLD: if (!bus.hold) state_d = (ret_run_q || (&full_d)) ? RUN : FILL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ret_run_q <= 1'b0;
      c0_q      <= '0;
      c1_q      <= '0;
      c2_q      <= '0;
      c3_q      <= '0;
      ld_q      <= '0;
      ov_q      <= 1'b0;
      drop_q    <= 1'b0;
      for (int k = 0; k < 4; k++) f_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      ret_run_q <= ret_run_d;
      ld_q      <= {tick30, tick5, tick1, accept};
      ov_q      <= ov_d;
      drop_q    <= drop_d;
      if (bus.stop) begin
        c0_q <= '0;
        c1_q <= '0;
        c2_q <= '0;
        c3_q <= '0;
        for (int k = 0; k < 4; k++) f_q[k] <= '0;
      end else begin
        if (accept) c0_q <= tick1   ? '0 : c0_q + 1'b1;
        if (tick1)  c1_q <= tick5   ? '0 : c1_q + 8'd1;
        if (tick5)  c2_q <= tick30  ? '0 : c2_q + 8'd1;
        if (tick30) c3_q <= tick240 ? '0 : c3_q + 8'd1;
        for (int k = 0; k < 4; k++) f_q[k] <= f_d[k];
      end
    end
  end

  assign bus.ld_s1     = ld_q[0];
  assign bus.ld_s2     = ld_q[1];
  assign bus.ld_s3     = ld_q[2];
  assign bus.ld_s4     = ld_q[3];
  assign bus.full      = full_now;
  assign bus.out_valid = ov_q;
  assign bus.state     = state_q;
  assign bus.drop      = drop_q;

`ifdef SCHED_STATUS_EN
  logic [15:0] epoch_cnt_q, drop_cnt_q;

  // Status survives stop; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (ov_d) epoch_cnt_q <= epoch_cnt_q + 16'd1;
      if (drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.epoch_cnt = epoch_cnt_q;
  assign bus.drop_cnt  = drop_cnt_q;
`endif
endmodule

// File: tb/tb_epoch_window_sched.sv
// Bench for epoch_window_sched with small cascade parameters: vector table, directed corner
// sequences and randomized traffic, all checked against a sample-count based reference model.
module tb_epoch_window_sched;
  localparam int SPS  = 4;
  localparam int N5   = 2;
  localparam int N30  = 2;
  localparam int N240 = 2;
  localparam int DEP  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  epoch_window_sched_if bus();

  epoch_window_sched #(
    .SPS(SPS), .N_5S(N5), .N_30S(N30), .N_240S(N240),
    .D1(DEP), .D2(DEP), .D3(DEP), .D4(DEP), .CW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: samples accepted since the last clear, loads presented per stage.
  int       m_state, m_ret, m_n;
  int       m_loads [4];
  bit [3:0] m_ld;
  bit       m_ov, m_drop;
  int       m_epoch, m_dropc;

  typedef struct {
    bit r, s, p, h, v;
    bit [3:0] ld;
    bit [3:0] full;
    bit [1:0] st;
    bit drop;
    bit ov;
  } vec_t;
  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_full();
    logic [3:0] f;
    for (int k = 0; k < 4; k++) f[k] = (m_loads[k] >= DEP);
    return f;
  endfunction

  function automatic logic [12:0] dut_vec();
    return {bus.ld_s4, bus.ld_s3, bus.ld_s2, bus.ld_s1, bus.full, bus.out_valid, bus.state, bus.drop};
  endfunction

  function automatic logic [12:0] exp_vec();
    return {m_ld, m_full(), m_ov, 2'(m_state), m_drop};
  endfunction

  task automatic model_update(input bit r, s, p, h, v);
    bit acc, allf, fnow;
    int la [4];
    bit [3:0] nld;
    bit ov;
    if (r) begin
      m_state = 0; m_ret = 0; m_n = 0; m_ld = '0; m_ov = 0; m_drop = 0;
      m_epoch = 0; m_dropc = 0;
      for (int k = 0; k < 4; k++) m_loads[k] = 0;
      return;
    end
    acc  = v && (m_state == 1 || m_state == 2) && !p;
    allf = 1'b1;
    for (int k = 0; k < 4; k++) begin
      la[k] = m_loads[k] + int'(m_ld[k]);
      if (la[k] < DEP) allf = 1'b0;
    end
    nld = '0;
    ov  = 1'b0;
    if (acc) begin
      m_n++;
      nld[0] = 1'b1;
      nld[1] = (m_n % SPS == 0);
      nld[2] = (m_n % (SPS * N5) == 0);
      nld[3] = (m_n % (SPS * N5 * N30) == 0);
      ov     = (m_n % (SPS * N5 * N30 * N240) == 0) && allf;
    end
    m_drop = v && !acc;
    if (p) begin
      m_n = 0;
      for (int k = 0; k < 4; k++) la[k] = 0;
    end
    fnow = 1'b1;
    for (int k = 0; k < 4; k++) begin
      m_loads[k] = la[k];
      if (la[k] < DEP) fnow = 1'b0;
    end
    m_ld = nld;
    m_ov = ov;
    m_epoch = (m_epoch + int'(ov)) % 65536;
    if (m_drop && m_dropc < 65535) m_dropc++;
    if (p) m_state = 0;
    else if (m_state == 0) begin
      if (s && !h) m_state = 1;
    end else if (m_state == 1) begin
      if (h) begin m_ret = 1; m_state = 3; end
      else if (fnow) m_state = 2;
    end else if (m_state == 2) begin
      if (h) begin m_ret = 2; m_state = 3; end
    end else if (!h) begin
      m_state = (m_ret == 2 || fnow) ? 2 : 1;
    end
  endtask

  task automatic step(input bit r, s, p, h, v);
    rst              = r;
    bus.start        = s;
    bus.stop         = p;
    bus.hold         = h;
    bus.sample_valid = v;
    model_update(r, s, p, h, v);
    @(posedge clk);
    #1;
    check("model", 32'(dut_vec()), 32'(exp_vec()));
`ifdef SCHED_STATUS_EN
    check("epoch_cnt_model", 32'(bus.epoch_cnt), 32'(m_epoch));
    check("drop_cnt_model", 32'(bus.drop_cnt), 32'(m_dropc));
`endif
  endtask

  // Feed continuous samples; report how many ld_s1 strobes were seen when out_valid first rose.
  task automatic run_until_ov(output int ld_at_ov, output int run_at, output logic [3:0] ld_vec);
    int ldc = 0;
    ld_at_ov = -1;
    run_at   = -1;
    ld_vec   = '0;
    for (int i = 0; i < 100 && ld_at_ov < 0; i++) begin
      step(0, 0, 0, 0, 1);
      if (bus.ld_s1) ldc++;
      if (bus.state == 2'b10 && run_at < 0) run_at = ldc;
      if (bus.out_valid) begin
        ld_at_ov = ldc;
        ld_vec   = {bus.ld_s4, bus.ld_s3, bus.ld_s2, bus.ld_s1};
      end
    end
  endtask

  initial begin
    int ld_at_ov, run_at, drops, strobes;
    logic [3:0] ldv;
    bit h;

    //             r  s  p  h  v   ld       full     st     drop ov
    tbl[0]  = '{1, 0, 0, 0, 0, 4'b0000, 4'b0000, 2'd0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 1, 4'b0000, 4'b0000, 2'd0, 1, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 4'b0000, 4'b0000, 2'd1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 4'b0001, 4'b0000, 2'd1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 4'b0000, 4'b0000, 2'd1, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 1, 4'b0001, 4'b0000, 2'd1, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 4'b0000, 4'b0001, 2'd1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 1, 4'b0001, 4'b0001, 2'd1, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 4'b0000, 4'b0001, 2'd1, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 4'b0011, 4'b0001, 2'd1, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 1, 4'b0001, 4'b0001, 2'd3, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 4'b0000, 4'b0001, 2'd1, 1, 0};
    tbl[12] = '{0, 0, 1, 0, 1, 4'b0000, 4'b0000, 2'd0, 1, 0};
    tbl[13] = '{0, 1, 0, 1, 0, 4'b0000, 4'b0000, 2'd0, 0, 0};
    tbl[14] = '{0, 1, 0, 0, 0, 4'b0000, 4'b0000, 2'd1, 0, 0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].h, tbl[i].v);
      check($sformatf("tbl[%0d]", i),
            32'({bus.ld_s4, bus.ld_s3, bus.ld_s2, bus.ld_s1, bus.full, bus.state, bus.drop, bus.out_valid}),
            32'({tbl[i].ld, tbl[i].full, tbl[i].st, tbl[i].drop, tbl[i].ov}));
    end

    // Continuous fill from FILL: RUN after sample 32, first result with sample 64.
    run_until_ov(ld_at_ov, run_at, ldv);
    check("run_after_32", 32'(run_at), 32'd33);
    check("first_ov_sample", 32'(ld_at_ov), 32'd64);
    check("ov_with_all_strobes", 32'(ldv), 32'hF);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);

    // Hold for 10 cycles in RUN with samples present.
    drops = 0;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1, 1);
      if (bus.drop) drops++;
      if (i > 0 && (bus.ld_s1 || bus.ld_s2 || bus.ld_s3 || bus.ld_s4)) strobes++;
      if (i == 9) check("hold_state", 32'(bus.state), 32'd3);
    end
    step(0, 0, 0, 0, 1);
    if (bus.drop) drops++;
    if (bus.ld_s1) strobes++;
    check("hold_drops", 32'(drops), 32'd10);
    check("hold_strobes", 32'(strobes), 32'd0);
    check("hold_full_kept", 32'(bus.full), 32'hF);
    step(0, 0, 0, 0, 1);
    check("resume_ld_s1", 32'(bus.ld_s1), 32'd1);

    // Stop in RUN with a sample present.
    step(0, 0, 1, 0, 1);
    check("stop_vec", 32'({bus.state, bus.full, bus.ld_s1, bus.ld_s2, bus.ld_s3, bus.ld_s4, bus.drop}),
          32'({2'b00, 4'b0000, 4'b0000, 1'b1}));
    step(0, 1, 0, 0, 0);
    check("restart_fill", 32'(bus.state), 32'd1);
    run_until_ov(ld_at_ov, run_at, ldv);
    check("restart_ov_sample", 32'(ld_at_ov), 32'd64);

    // rst in the cycle that would launch ld_s4.
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    check("rst_at_ld_s4", 32'(dut_vec()), 32'd0);

`ifdef SCHED_STATUS_EN
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    begin
      int ovc = 0;
      for (int i = 0; i < 200 && ovc < 3; i++) begin
        step(0, 0, 0, 0, 1);
        if (bus.out_valid) ovc++;
      end
    end
    check("epoch_cnt_3", 32'(bus.epoch_cnt), 32'd3);
    check("drop_cnt_5", 32'(bus.drop_cnt), 32'd5);
    step(0, 0, 1, 0, 0);
    check("epoch_keep_stop", 32'(bus.epoch_cnt), 32'd3);
    check("drop_keep_stop", 32'(bus.drop_cnt), 32'd5);
    step(1, 0, 0, 0, 0);
    check("status_rst", 32'({bus.epoch_cnt, bus.drop_cnt}), 32'd0);
`endif

    // Randomized traffic against the model.
    h = 1'b0;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) h = ~h;
      step($urandom_range(0, 799) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 299) == 0,
           h,
           $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
